dmem_resp: RTL and testbench

Data-memory responder on the core's load/store port. It is the slave end of the path driven by the instruction decoder's LOAD/STORE controls (dmem_we, ALU address, RS2 data). It accepts one word request at a time over a valid/ready handshake, reads or writes an internal word-addressed RAM, and returns a response with a valid/ready handshake. Misaligned and out-of-range accesses return an error response. Saturating access counters are provided for debug.

---
 rtl/dmem_resp.sv | 61 ++++++
 tb/tb_dmem_resp.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_resp.sv
// dmem_resp: word-addressed data RAM behind a valid/ready load/store request/response port
module dmem_resp #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_err,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] wr_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] IDLE = 2'd0, RD = 2'd1, RSP = 2'd2;
  logic [1:0] state;
  logic [31:0] mem [DEPTH];
  logic [31:0] off, rd_q;
  logic [AW-1:0] idx;
  logic err, acc;
  assign off = req_addr - BASE_ADDR;
  assign idx = off[AW+1:2];
  assign err = (|off[1:0]) || (|off[31:AW+2]);
  assign req_ready = (state == IDLE) && !rst;
  assign acc = req_valid && req_ready;
  assign rsp_valid = state == RSP;
  always_ff @(posedge clk) begin
    if (acc && req_we && !err) mem[idx] <= req_wdata;
    if (acc) rd_q <= mem[idx];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      rd_count  <= '0;
      wr_count  <= '0;
    end else if (state == IDLE) begin
      if (acc) begin
        state     <= (err || req_we) ? RSP : RD;
        rsp_err   <= err;
        rsp_rdata <= '0;
        if (!err && req_we && wr_count != '1) wr_count <= wr_count + 1'b1;
      end
    end else if (state == RD) begin
      state     <= RSP;
      rsp_rdata <= rd_q;
      rsp_err   <= 1'b0;
      if (rd_count != '1) rd_count <= rd_count + 1'b1;
    end else if (rsp_ready) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_dmem_resp.sv
// tb_dmem_resp: directed checks of dmem_resp handshakes, addressing, reset and counters
module tb_dmem_resp;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic req_valid = 0, req_we = 0, rsp_ready = 0, req_ready, rsp_valid, rsp_err;
  logic [31:0] req_addr = 0, req_wdata = 0, rsp_rdata;
  logic [15:0] rd_count, wr_count;
  logic s_req_valid = 0, s_req_we = 0, s_rsp_ready = 0, s_req_ready, s_rsp_valid, s_rsp_err;
  logic [31:0] s_req_addr = 0, s_req_wdata = 0, s_rsp_rdata;
  logic [1:0] s_rd_count, s_wr_count;
  int n_cmp = 0, n_bad = 0;

  dmem_resp dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rd_count(rd_count), .wr_count(wr_count)
  );

  dmem_resp #(.DEPTH(16), .BASE_ADDR(32'h100), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .req_valid(s_req_valid), .req_ready(s_req_ready), .req_we(s_req_we),
    .req_addr(s_req_addr), .req_wdata(s_req_wdata), .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready),
    .rsp_rdata(s_rsp_rdata), .rsp_err(s_rsp_err), .rd_count(s_rd_count), .wr_count(s_wr_count)
  );

  // Returns at the first negedge where rsp_valid is high; lat counts cycles after the accept edge.
  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d, output int lat);
    int w = 0;
    @(negedge clk);
    while (!req_ready && w < 50) begin @(negedge clk); w++; end
    req_valid = 1; req_we = we; req_addr = a; req_wdata = d;
    @(posedge clk); #1 req_valid = 0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 50);
  endtask

  task automatic ack();
    rsp_ready = 1;
    @(posedge clk); #1 rsp_ready = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", rsp_valid); end
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready_after: got %b want 1", req_ready); end
    n_cmp++; if ({rd_count, wr_count} !== 32'h0) begin n_bad++; $display("FAIL rst_counts: got %h/%h want 0/0", rd_count, wr_count); end
    n_cmp++; if ({rsp_err, rsp_rdata} !== 33'h0) begin n_bad++; $display("FAIL rst_rsp: got err %b data %h want 0/0", rsp_err, rsp_rdata); end
  endtask

  task automatic test_store_load();
    int lat;
    issue(1, 32'h10, 32'hDEADBEEF, lat);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL st_lat: got %0d want 1", lat); end
    n_cmp++; if ({rsp_err, rsp_rdata} !== 33'h0) begin n_bad++; $display("FAIL st_rsp: got err %b data %h want 0/0", rsp_err, rsp_rdata); end
    n_cmp++; if (wr_count !== 16'd1) begin n_bad++; $display("FAIL st_wr_count: got %0d want 1", wr_count); end
    ack();
    issue(0, 32'h10, 32'h0, lat);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL ld_lat: got %0d want 2", lat); end
    n_cmp++; if (rsp_rdata !== 32'hDEADBEEF || rsp_err !== 1'b0) begin n_bad++; $display("FAIL ld_data: got %h err %b want deadbeef/0", rsp_rdata, rsp_err); end
    n_cmp++; if (rd_count !== 16'd1) begin n_bad++; $display("FAIL ld_rd_count: got %0d want 1", rd_count); end
    ack();
  endtask

  task automatic test_errors();
    int lat;
    issue(1, 32'h0, 32'hA5A5_0000, lat); ack();
    issue(0, 32'h12, 32'h0, lat);
    n_cmp++; if ({rsp_err, rsp_rdata} !== {1'b1, 32'h0}) begin n_bad++; $display("FAIL misalign: got err %b data %h want 1/0", rsp_err, rsp_rdata); end
    ack();
    issue(0, 32'h1000, 32'h0, lat);
    n_cmp++; if ({rsp_err, rsp_rdata} !== {1'b1, 32'h0} || lat !== 1) begin n_bad++; $display("FAIL oor_load: got err %b data %h lat %0d want 1/0/1", rsp_err, rsp_rdata, lat); end
    n_cmp++; if (rd_count !== 16'd1 || wr_count !== 16'd2) begin n_bad++; $display("FAIL err_counts: got %0d/%0d want 1/2", rd_count, wr_count); end
    ack();
    issue(1, 32'h0FFF_FFFC, 32'hBAD0_BAD0, lat);
    n_cmp++; if (rsp_err !== 1'b1 || wr_count !== 16'd2) begin n_bad++; $display("FAIL oor_store: got err %b wr %0d want 1/2", rsp_err, wr_count); end
    ack();
    issue(0, 32'h0, 32'h0, lat);
    n_cmp++; if (rsp_rdata !== 32'hA5A5_0000 || rsp_err !== 1'b0) begin n_bad++; $display("FAIL word0_kept: got %h err %b want a5a50000/0", rsp_rdata, rsp_err); end
    ack();
  endtask

  task automatic test_backpressure();
    int lat;
    issue(0, 32'h10, 32'h0, lat);
    req_valid = 1; req_we = 1; req_addr = 32'h10; req_wdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF || req_ready !== 1'b0) begin
        n_bad++; $display("FAIL stall_%0d: got valid %b data %h ready %b want 1/deadbeef/0", i, rsp_valid, rsp_rdata, req_ready);
      end
    end
    ack();
    req_valid = 0;
    @(negedge clk);
    n_cmp++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL release: got ready %b valid %b data %h want 1/0/deadbeef", req_ready, rsp_valid, rsp_rdata);
    end
    issue(0, 32'h10, 32'h0, lat);
    n_cmp++; if (rsp_rdata !== 32'hDEADBEEF || wr_count !== 16'd2 || rd_count !== 16'd4) begin
      n_bad++; $display("FAIL stall_ignored: got %h wr %0d rd %0d want deadbeef/2/4", rsp_rdata, wr_count, rd_count);
    end
    ack();
  endtask

  task automatic test_last_word();
    int lat;
    issue(1, 32'hFFC, 32'h1234_5678, lat); ack();
    issue(0, 32'hFFC, 32'h0, lat);
    n_cmp++; if (rsp_rdata !== 32'h1234_5678 || rsp_err !== 1'b0) begin n_bad++; $display("FAIL last_word: got %h err %b want 12345678/0", rsp_rdata, rsp_err); end
    ack();
    issue(0, 32'h0, 32'h0, lat);
    n_cmp++; if (rsp_rdata !== 32'hA5A5_0000) begin n_bad++; $display("FAIL no_alias: got %h want a5a50000", rsp_rdata); end
    ack();
  endtask

  task automatic test_reset_mid();
    int lat;
    @(negedge clk);
    req_valid = 1; req_we = 1; req_addr = 32'h40; req_wdata = 32'hCAFE_F00D;
    @(posedge clk); #1 req_valid = 0; rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || wr_count !== 16'd0) begin
      n_bad++; $display("FAIL rst_after_st: got valid %b ready %b wr %0d want 0/1/0", rsp_valid, req_ready, wr_count);
    end
    req_valid = 1; req_we = 0; req_addr = 32'h40;
    @(posedge clk); #1 req_valid = 0; rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rd_count !== 16'd0 || wr_count !== 16'd0) begin
      n_bad++; $display("FAIL rst_in_rd: got valid %b ready %b rd %0d wr %0d want 0/1/0/0", rsp_valid, req_ready, rd_count, wr_count);
    end
    issue(0, 32'h40, 32'h0, lat);
    n_cmp++; if (rsp_rdata !== 32'hCAFE_F00D || rd_count !== 16'd1) begin n_bad++; $display("FAIL st_persist: got %h rd %0d want cafef00d/1", rsp_rdata, rd_count); end
    ack();
  endtask

  task automatic test_saturate();
    int acc = 0, cyc = 0;
    s_rsp_ready = 1; s_req_valid = 1; s_req_we = 1; s_req_addr = 32'h104;
    while (acc < 5 && cyc < 100) begin
      @(negedge clk); cyc++;
      if (s_req_ready) begin acc++; s_req_wdata = acc; end
    end
    @(posedge clk); #1 s_req_valid = 0;
    repeat (4) @(negedge clk);
    n_cmp++; if (s_wr_count !== 2'd3 || acc !== 5) begin n_bad++; $display("FAIL wr_sat: got %0d after %0d stores want 3 after 5", s_wr_count, acc); end
    s_req_valid = 1; s_req_we = 0; s_req_addr = 32'hFC;
    @(posedge clk); #1 s_req_valid = 0;
    @(negedge clk);
    n_cmp++; if (s_rsp_valid !== 1'b1 || s_rsp_err !== 1'b1 || s_rd_count !== 2'd0) begin
      n_bad++; $display("FAIL below_base: got valid %b err %b rd %0d want 1/1/0", s_rsp_valid, s_rsp_err, s_rd_count);
    end
    @(negedge clk);
    s_req_valid = 1; s_req_addr = 32'h104;
    @(posedge clk); #1 s_req_valid = 0;
    @(negedge clk); @(negedge clk);
    n_cmp++; if (s_rsp_valid !== 1'b1 || s_rsp_rdata !== 32'd5 || s_rd_count !== 2'd1) begin
      n_bad++; $display("FAIL base_load: got valid %b data %h rd %0d want 1/5/1", s_rsp_valid, s_rsp_rdata, s_rd_count);
    end
    s_rsp_ready = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_store_load();
    test_errors();
    test_backpressure();
    test_last_word();
    test_reset_mid();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
